fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Pointer and flag controller for the synchronous FIFO. It turns push/pop requests into the memory's write-enable, write pointer and read pointer, and reports full, empty, fill level and sticky error flags. It sits beside the dual-port memory array in the FIFO top level. Read data comes combinationally from the memory at `read_pointer`, so the FIFO is first-word-fall-through.

## Interface
Parameters:
- `w_address`, default 4: pointer index width. Pointers carry one extra wrap bit.
- `L_fifo`, default 16: depth. Must equal 2**w_address; elaboration fails otherwise.
- `AF_LEVEL`, default 12: almost-full threshold. Present only with the watermark macro.
- `AE_LEVEL`, default 4: almost-empty threshold. Present only with the watermark macro.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  push request.
- `rd_en`  in  1  pop request.
- `clr_err`  in  1  synchronous clear of the sticky error flags.
- `wr_en_ptr`  out  1  memory write strobe.
- `write_pointer`  out  w_address+1  next write slot plus wrap bit.
- `read_pointer`  out  w_address+1  head slot plus wrap bit.
- `full`  out  1  FIFO is full.
- `empty`  out  1  FIFO is empty.
- `count`  out  w_address+1  number of stored entries, 0..L_fifo.
- `overflow`  out  1  sticky: a push was attempted while full.
- `underflow`  out  1  sticky: a pop was attempted while empty.
- `almost_full`  out  1  watermark flag; present only with the macro.
- `almost_empty`  out  1  watermark flag; present only with the macro.

## Operation
- Push accepted iff `wr_en && !full`. A pop in the same cycle does not unblock a push to a full FIFO.
- Pop accepted iff `rd_en && !empty`. A push in the same cycle does not unblock a pop from an empty FIFO.
- `wr_en_ptr` = push accepted (combinational). The memory writes at `write_pointer[w_address-1:0]` on the same edge that the pointer advances.
- Each accepted push increments `write_pointer` by 1. Each accepted pop increments `read_pointer` by 1. Both wrap modulo 2**(w_address+1), so the wrap bit toggles every L_fifo operations.
- `empty` = (write_pointer == read_pointer).
- `full` = MSBs differ and the low w_address bits are equal.
- `count` = write_pointer - read_pointer, modulo 2**(w_address+1).
- A push and a pop accepted in the same cycle advance both pointers; `count` is unchanged.
- `overflow` sets when `wr_en && full`. `underflow` sets when `rd_en && empty`. Both hold until `clr_err` or reset.
- If `clr_err` and a new error occur in the same cycle, the set wins.
- Rejected requests never move a pointer and never assert `wr_en_ptr`.

## Timing
- Reset (asynchronous, immediate): both pointers = 0, overflow = 0, underflow = 0. As a result empty = 1, full = 0, count = 0, and almost_empty = 1 (with the macro). The memory contents are not reset.
- Pointers and sticky flags are registered. `full`, `empty`, `count` and the watermarks are combinational from the registered pointers, so they reflect an operation one cycle after the accepting edge.
- Pop-to-data latency is 0: `READ_DATA` at the head is valid whenever `empty` = 0.
- Write-to-visible latency is 1 cycle: `empty` deasserts the cycle after the first accepted push.
- Reset asserted mid-operation discards all queued entries; the state after release is identical to power-up.

## Configuration
- Macro `FIFO_CTRL_WATERMARK_EN`.
- Defined: `almost_full` = (count >= AF_LEVEL) and `almost_empty` = (count <= AE_LEVEL), both combinational, and the two threshold parameters exist.
- Undefined: the ports, the parameters and their logic are absent. All other behaviour is identical.

## Structure
- The shared package `fifo_pkg` holds the default depth, the address-width constants and the pointer typedef of w_address+1 bits, so the memory and the controller agree on pointer format.
- One sub-module, `fifo_ptr`: a wrapping (w_address+1)-bit pointer counter with an increment enable and asynchronous reset. It is instantiated twice, once for read and once for write.

## Test plan
- Reset, then 16 pushes of 0x00..0x0F: full = 1 after the 16th push, count = 16, write_pointer = 5'b10000, no overflow.
- Full FIFO, push with pop in the same cycle: the pop is accepted, the push is rejected, overflow = 1, count = 15.
- Empty FIFO, pop: underflow = 1, pointers unchanged. Then `clr_err` for 1 cycle: underflow = 0.
- 40 alternating push/pop pairs: both pointers wrap past 31 to 0, data is read out in order, empty = 1 at the end.
- With the macro defined, push 12 entries: almost_full rises on the cycle count = 12. Pop down to 4 entries: almost_empty rises.
- Assert `rst` asynchronously mid-burst with count = 7: all outputs return to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default depth, address widths and the pointer
// format (index plus one wrap bit) used by both the memory and fifo_ctrl.
package fifo_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int ADDR_W     = $clog2(FIFO_DEPTH);
    localparam int PTR_W      = ADDR_W + 1;

    // Pointer: low ADDR_W bits index the memory, the MSB is the wrap bit.
    typedef logic [PTR_W-1:0] ptr_t;

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter: advances by one when inc_i is high and rolls
// over modulo 2**W, so the top bit toggles once per lap of the memory.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int W = PTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Next pointer value: hold, or step by one with natural wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    // Pointer register, cleared immediately by reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule : fifo_ptr

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for the synchronous first-word-fall-through
// FIFO. Converts push/pop requests into the memory write strobe and the
// read/write pointers, and derives full, empty, count and sticky errors.
// Optional watermark flags (almost_full / almost_empty) and their threshold
// parameters exist only when FIFO_CTRL_WATERMARK_EN is defined.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int w_address = ADDR_W,
    parameter int L_fifo    = FIFO_DEPTH
`ifdef FIFO_CTRL_WATERMARK_EN
    ,
    parameter int AF_LEVEL  = 12,
    parameter int AE_LEVEL  = 4
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic               clr_err,
    output logic               wr_en_ptr,
    output logic [w_address:0] write_pointer,
    output logic [w_address:0] read_pointer,
    output logic               full,
    output logic               empty,
    output logic [w_address:0] count,
    output logic               overflow,
    output logic               underflow
`ifdef FIFO_CTRL_WATERMARK_EN
    ,
    output logic               almost_full,
    output logic               almost_empty
`endif
);

    // The wrap-bit scheme only works when the depth is a power of two that
    // matches the pointer index width.
    if (L_fifo != (1 << w_address)) begin : g_bad_depth
        $error("fifo_ctrl: L_fifo must equal 2**w_address");
    end

    logic push_ok;
    logic pop_ok;
    logic overflow_q;
    logic overflow_d;
    logic underflow_q;
    logic underflow_d;

    // A simultaneous pop never frees room for a push, and a simultaneous push
    // never supplies data for a pop: both decisions use the registered flags.
    assign push_ok   = wr_en && !full;
    assign pop_ok    = rd_en && !empty;
    assign wr_en_ptr = push_ok;

    fifo_ptr #(.W(w_address + 1)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (push_ok),
        .ptr_o (write_pointer)
    );

    fifo_ptr #(.W(w_address + 1)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (pop_ok),
        .ptr_o (read_pointer)
    );

    // Level flags come straight from the registered pointers. The memory array
    // itself is never reset; empty hides its stale contents after reset.
    assign empty = (write_pointer == read_pointer);
    assign full  = (write_pointer[w_address] != read_pointer[w_address]) &&
                   (write_pointer[w_address-1:0] == read_pointer[w_address-1:0]);
    assign count = write_pointer - read_pointer;

    // Sticky error next-state: a new error wins over a clear in the same cycle.
    // NOTE: every output of this always_comb gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    // Sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef FIFO_CTRL_WATERMARK_EN
    assign almost_full  = (32'(count) >= AF_LEVEL);
    assign almost_empty = (32'(count) <= AE_LEVEL);
`endif

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a vector table for single-cycle
// behaviour plus directed sequences for fill, wrap, watermark and reset.
module tb_fifo_ctrl;
    import fifo_pkg::*;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic       clr_err;
    logic       wr_en_ptr;
    ptr_t       write_pointer;
    ptr_t       read_pointer;
    logic       full;
    logic       empty;
    ptr_t       count;
    logic       overflow;
    logic       underflow;
`ifdef FIFO_CTRL_WATERMARK_EN
    logic       almost_full;
    logic       almost_empty;
`endif

    logic [7:0] wdata;
    logic [7:0] mem [FIFO_DEPTH];
    logic [7:0] head;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .clr_err       (clr_err),
        .wr_en_ptr     (wr_en_ptr),
        .write_pointer (write_pointer),
        .read_pointer  (read_pointer),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
`ifdef FIFO_CTRL_WATERMARK_EN
        ,
        .almost_full   (almost_full),
        .almost_empty  (almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory beside the controller, as in the FIFO top level.
    always @(posedge clk) begin
        if (wr_en_ptr) mem[write_pointer[ADDR_W-1:0]] <= wdata;
    end
    assign head = mem[read_pointer[ADDR_W-1:0]];

    typedef struct {
        logic       wr, rd, clr;
        logic       e_wen;
        logic [4:0] e_wp, e_rp;
        logic       e_full, e_empty;
        logic [4:0] e_cnt;
        logic       e_ovf, e_udf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after a falling edge and let combinational logic settle.
    task automatic apply(input logic w, input logic r, input logic c, input logic [7:0] d);
        wr_en   = w;
        rd_en   = r;
        clr_err = c;
        wdata   = d;
        #1;
    endtask

    // Cross one rising edge and return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        wdata   = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " wp"},    32'(write_pointer), 0);
        check({tag, " rp"},    32'(read_pointer),  0);
        check({tag, " count"}, 32'(count),         0);
        check({tag, " empty"}, 32'(empty),         1);
        check({tag, " full"},  32'(full),          0);
        check({tag, " ovf"},   32'(overflow),      0);
        check({tag, " udf"},   32'(underflow),     0);
`ifdef FIFO_CTRL_WATERMARK_EN
        check({tag, " ae"},    32'(almost_empty),  1);
        check({tag, " af"},    32'(almost_full),   0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // wr rd clr | wen | wp rp | full empty cnt | ovf udf
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1}; // pop empty
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}; // clear
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0}; // push
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 5'd1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0}; // push+pop
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 5'd2, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}; // pop last
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 5'd2, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1}; // set beats clear
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 5'd2, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}; // clear
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 5'd2, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1}; // push+pop on empty
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 5'd2, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0}; // clear
        vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd3, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}; // pop

        rst = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wdata = '0;
        do_reset();
        #1;
        check_reset_state("reset");

        // ---- vector table ----
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].wr, vecs[i].rd, vecs[i].clr, 8'(i));
            check($sformatf("vec%0d wen", i), 32'(wr_en_ptr), 32'(vecs[i].e_wen));
            tick();
            check($sformatf("vec%0d wp", i),    32'(write_pointer), 32'(vecs[i].e_wp));
            check($sformatf("vec%0d rp", i),    32'(read_pointer),  32'(vecs[i].e_rp));
            check($sformatf("vec%0d full", i),  32'(full),          32'(vecs[i].e_full));
            check($sformatf("vec%0d empty", i), 32'(empty),         32'(vecs[i].e_empty));
            check($sformatf("vec%0d count", i), 32'(count),         32'(vecs[i].e_cnt));
            check($sformatf("vec%0d ovf", i),   32'(overflow),      32'(vecs[i].e_ovf));
            check($sformatf("vec%0d udf", i),   32'(underflow),     32'(vecs[i].e_udf));
        end

        // ---- fill to full with 0x00..0x0F ----
        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 1'b0, 1'b0, 8'(i));
            check($sformatf("fill%0d wen", i), 32'(wr_en_ptr), 1);
            tick();
            if (i == 14) check("fill15 not full", 32'(full), 0);
        end
        apply(1'b0, 1'b0, 1'b0, 8'h00);
        check("fill full",  32'(full),          1);
        check("fill count", 32'(count),         16);
        check("fill wp",    32'(write_pointer), 32'h10);
        check("fill ovf",   32'(overflow),      0);
        check("fill head",  32'(head),          32'h00);

        // ---- push with pop on a full FIFO: pop accepted, push rejected ----
        apply(1'b1, 1'b1, 1'b0, 8'hAA);
        check("fullpp wen", 32'(wr_en_ptr), 0);
        tick();
        apply(1'b0, 1'b0, 1'b0, 8'h00);
        check("fullpp ovf",   32'(overflow),      1);
        check("fullpp count", 32'(count),         15);
        check("fullpp rp",    32'(read_pointer),  1);
        check("fullpp wp",    32'(write_pointer), 32'h10);
        check("fullpp full",  32'(full),          0);
        check("fullpp head",  32'(head),          32'h01);

        // ---- 40 push/pop pairs: pointers wrap past 31 ----
        do_reset();
        for (int i = 0; i < 40; i++) begin
            apply(1'b1, 1'b0, 1'b0, 8'(i + 8'h40));
            tick();
            check($sformatf("alt%0d nonempty", i), 32'(empty), 0);
            check($sformatf("alt%0d head", i),     32'(head),  32'(i + 8'h40));
            if (i == 31) check("alt wp wrap", 32'(write_pointer), 0);
            apply(1'b0, 1'b1, 1'b0, 8'h00);
            tick();
            check($sformatf("alt%0d empty", i), 32'(empty), 1);
        end
        apply(1'b0, 1'b0, 1'b0, 8'h00);
        check("alt wp end",  32'(write_pointer), 8);
        check("alt rp end",  32'(read_pointer),  8);
        check("alt udf",     32'(underflow),     0);

`ifdef FIFO_CTRL_WATERMARK_EN
        // ---- watermarks ----
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            apply(1'b1, 1'b0, 1'b0, 8'(i));
            tick();
            check($sformatf("wm push%0d af", i), 32'(almost_full),  (i >= 12) ? 1 : 0);
            check($sformatf("wm push%0d ae", i), 32'(almost_empty), (i <= 4) ? 1 : 0);
        end
        for (int c = 11; c >= 4; c--) begin
            apply(1'b0, 1'b1, 1'b0, 8'h00);
            tick();
            check($sformatf("wm pop%0d af", c), 32'(almost_full),  0);
            check($sformatf("wm pop%0d ae", c), 32'(almost_empty), (c <= 4) ? 1 : 0);
        end
        apply(1'b0, 1'b0, 1'b0, 8'h00);
`endif

        // ---- asynchronous reset mid-burst with count = 7 ----
        do_reset();
        apply(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, 1'b0, 1'b0, 8'(i));
            tick();
        end
        check("async pre count", 32'(count),     7);
        check("async pre udf",   32'(underflow), 1);
        apply(1'b1, 1'b0, 1'b0, 8'h77);
        #2;
        rst   = 1'b1;
        wr_en = 1'b0;
        #1;
        check_reset_state("async");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state("post-rst");
        apply(1'b1, 1'b0, 1'b0, 8'h5A);
        tick();
        apply(1'b0, 1'b0, 1'b0, 8'h00);
        check("post-rst count", 32'(count), 1);
        check("post-rst head",  32'(head),  32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_ctrl
